// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : control_sequencer                                          |
// | Description : Hardwired Mini-SRC control unit. Runs the instruction      |
// |               fetch (T0-T2, with a memory-ready wait in T1) and then     |
// |               decodes the IR into per-step datapath strobes for register |
// |               ALU, immediate, mul/div, nop and halt instructions.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock        in   system clock, rising edge                            |
// |   clear        in   synchronous active-high reset; also gates strobes    |
// |   run          in   start request, sampled in IDLE                       |
// |   mem_ready    in   Mdatain valid this cycle                             |
// |   ir[31:0]     in   current IR contents                                  |
// |   Rin/Rout     out  one-hot GPR load enable / bus drive (bit n = Rn)     |
// |   *in, *out    out  register load strobes and bus drive selects         |
// |   Read, IncPC  out  MDR takes Mdatain / Z takes PC+1                     |
// |   ALU_Control  out  ALU operation code                                   |
// |   c_value      out  ir[18:0] sign-extended                               |
// |   halted       out  high in HALT                                         |
// |   illegal_op   out  one-cycle pulse in T3 on an unknown opcode           |
// |   mem_timeout  out  sticky fetch-timeout flag                            |
// |   state[3:0]   out  debug state encoding (IDLE=0, T0..T6=1..7, HALT=8)   |
// +--------------------------------------------------------------------------+
module control_sequencer #(
    parameter bit          AUTO_RUN       = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        Read,
    output logic        IncPC,
    output logic [4:0]  ALU_Control,
    output logic [31:0] c_value,
    output logic        halted,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [3:0]  state
);

    localparam logic [3:0] c_st_idle = 4'd0;
    localparam logic [3:0] c_st_t0   = 4'd1;
    localparam logic [3:0] c_st_t1   = 4'd2;
    localparam logic [3:0] c_st_t2   = 4'd3;
    localparam logic [3:0] c_st_t3   = 4'd4;
    localparam logic [3:0] c_st_t4   = 4'd5;
    localparam logic [3:0] c_st_t5   = 4'd6;
    localparam logic [3:0] c_st_t6   = 4'd7;
    localparam logic [3:0] c_st_halt = 4'd8;

    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_sub  = 5'b00100;
    localparam logic [4:0] c_op_and  = 5'b00101;
    localparam logic [4:0] c_op_or   = 5'b00110;
    localparam logic [4:0] c_op_shr  = 5'b00111;
    localparam logic [4:0] c_op_shra = 5'b01000;
    localparam logic [4:0] c_op_shl  = 5'b01001;
    localparam logic [4:0] c_op_ror  = 5'b01010;
    localparam logic [4:0] c_op_rol  = 5'b01011;
    localparam logic [4:0] c_op_addi = 5'b01100;
    localparam logic [4:0] c_op_andi = 5'b01101;
    localparam logic [4:0] c_op_ori  = 5'b01110;
    localparam logic [4:0] c_op_mul  = 5'b01111;
    localparam logic [4:0] c_op_div  = 5'b10000;
    localparam logic [4:0] c_op_neg  = 5'b10001;
    localparam logic [4:0] c_op_not  = 5'b10010;
    localparam logic [4:0] c_op_nop  = 5'b11010;
    localparam logic [4:0] c_op_halt = 5'b11011;

    // The wait counter holds the number of T1 cycles already completed, so
    // it only needs to reach TIMEOUT_CYCLES-1.
    localparam int              c_cnt_w    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [3:0]         r_state;
    logic [3:0]         w_next_state;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_halted;
    logic               r_mem_timeout;
    logic               w_timeout_hit;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [15:0] w_ra_hot;
    logic [15:0] w_rb_hot;
    logic [15:0] w_rc_hot;

    logic       w_is_reg;
    logic       w_is_unary;
    logic       w_is_imm;
    logic       w_is_muldiv;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic [4:0] w_imm_alu;

    assign w_opcode = ir[31:27];
    assign w_ra     = ir[26:23];
    assign w_rb     = ir[22:19];
    assign w_rc     = ir[18:15];
    assign w_ra_hot = 16'h0001 << w_ra;
    assign w_rb_hot = 16'h0001 << w_rb;
    assign w_rc_hot = 16'h0001 << w_rc;
    assign c_value  = {{13{ir[18]}}, ir[18:0]};

    // Instruction class decode
    always_comb begin
        w_is_reg     = 1'b0;
        w_is_unary   = 1'b0;
        w_is_imm     = 1'b0;
        w_is_muldiv  = 1'b0;
        w_is_halt    = 1'b0;
        w_is_illegal = 1'b0;
        w_imm_alu    = c_op_or;
        case (w_opcode)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_shr,
            c_op_shra, c_op_shl, c_op_ror, c_op_rol: w_is_reg = 1'b1;
            c_op_neg, c_op_not: begin
                w_is_reg   = 1'b1;
                w_is_unary = 1'b1;
            end
            c_op_addi: begin
                w_is_imm  = 1'b1;
                w_imm_alu = c_op_add;
            end
            c_op_andi: begin
                w_is_imm  = 1'b1;
                w_imm_alu = c_op_and;
            end
            c_op_ori:           w_is_imm    = 1'b1;
            c_op_mul, c_op_div: w_is_muldiv = 1'b1;
            c_op_nop:           ;
            c_op_halt:          w_is_halt   = 1'b1;
            default:            w_is_illegal = 1'b1;
        endcase
    end

    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_state == c_st_t1) &&
                           !mem_ready && (r_wait_cnt == c_cnt_last);

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (run || AUTO_RUN) w_next_state = c_st_t0;
            c_st_t0:   w_next_state = c_st_t1;
            c_st_t1: begin
                if (mem_ready)          w_next_state = c_st_t2;
                else if (w_timeout_hit) w_next_state = c_st_halt;
                else                    w_next_state = c_st_t1;
            end
            c_st_t2:   w_next_state = c_st_t3;
            c_st_t3: begin
                if (w_is_halt)                               w_next_state = c_st_halt;
                else if (w_is_reg || w_is_imm || w_is_muldiv) w_next_state = c_st_t4;
                else                                          w_next_state = c_st_t0;
            end
            c_st_t4:   w_next_state = c_st_t5;
            c_st_t5:   w_next_state = w_is_muldiv ? c_st_t6 : c_st_t0;
            c_st_t6:   w_next_state = c_st_t0;
            c_st_halt: w_next_state = c_st_halt;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state       <= c_st_idle;
            r_wait_cnt    <= '0;
            r_halted      <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= ((r_state == c_st_t1) && (w_next_state == c_st_t1)) ?
                          r_wait_cnt + c_cnt_one : '0;
            r_halted   <= (w_next_state == c_st_halt);
            if (w_timeout_hit) r_mem_timeout <= 1'b1;
        end
    end

    assign halted      = r_halted;
    assign mem_timeout = r_mem_timeout;
    assign state       = r_state;

    // Moore strobe decode; clear suppresses every strobe in the same cycle.
    always_comb begin
        Rin         = '0;
        Rout        = '0;
        PCin        = 1'b0;
        IRin        = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        PCout       = 1'b0;
        MDRout      = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        HIout       = 1'b0;
        LOout       = 1'b0;
        Cout        = 1'b0;
        Read        = 1'b0;
        IncPC       = 1'b0;
        ALU_Control = '0;
        illegal_op  = 1'b0;
        if (!clear) begin
            case (r_state)
                c_st_t0: begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
                c_st_t1: begin
                    // PC reloads with the same Z value on every wait cycle.
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                c_st_t2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                c_st_t3: begin
                    if (w_is_reg || w_is_imm) begin
                        Rout = w_rb_hot;
                        Yin  = 1'b1;
                    end else if (w_is_muldiv) begin
                        Rout = w_ra_hot;
                        Yin  = 1'b1;
                    end
                    illegal_op = w_is_illegal;
                end
                c_st_t4: begin
                    Zin = 1'b1;
                    if (w_is_imm) begin
                        Cout        = 1'b1;
                        ALU_Control = w_imm_alu;
                    end else if (w_is_muldiv) begin
                        Rout        = w_rb_hot;
                        ALU_Control = w_opcode;
                    end else begin
                        Rout        = w_is_unary ? w_rb_hot : w_rc_hot;
                        ALU_Control = w_opcode;
                    end
                end
                c_st_t5: begin
                    Zlowout = 1'b1;
                    if (w_is_muldiv) LOin = 1'b1;
                    else             Rin  = w_ra_hot;
                end
                c_st_t6: begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_control_sequencer                                       |
// | Description : Self-checking bench for control_sequencer. Each            |
// |               instruction is expanded into its expected cycle-by-cycle   |
// |               micro-step list, then replayed against the DUT.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] Rin, Rout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Cout, Read, IncPC;
    logic [4:0]  ALU_Control;
    logic [31:0] c_value;
    logic        halted, illegal_op, mem_timeout;
    logic [3:0]  state;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .Read(Read), .IncPC(IncPC),
        .ALU_Control(ALU_Control), .c_value(c_value), .halted(halted),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clock = ~clock;

    // Flag bit masks for the single-bit strobes
    localparam logic [16:0] F_PCIN   = 17'h10000;
    localparam logic [16:0] F_IRIN   = 17'h08000;
    localparam logic [16:0] F_MARIN  = 17'h04000;
    localparam logic [16:0] F_MDRIN  = 17'h02000;
    localparam logic [16:0] F_YIN    = 17'h01000;
    localparam logic [16:0] F_ZIN    = 17'h00800;
    localparam logic [16:0] F_HIIN   = 17'h00400;
    localparam logic [16:0] F_LOIN   = 17'h00200;
    localparam logic [16:0] F_PCOUT  = 17'h00100;
    localparam logic [16:0] F_MDROUT = 17'h00080;
    localparam logic [16:0] F_ZLOW   = 17'h00040;
    localparam logic [16:0] F_ZHIGH  = 17'h00020;
    localparam logic [16:0] F_COUT   = 17'h00004;
    localparam logic [16:0] F_READ   = 17'h00002;
    localparam logic [16:0] F_INCPC  = 17'h00001;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [16:0] fl;
        logic [4:0]  alu;
        logic        hlt;
        logic        ill;
        logic        tmo;
        logic [31:0] cv;
    } obs_t;

    typedef struct {
        string       tag;
        bit          run_v;
        bit          mr_v;
        bit          clr_v;
        logic [31:0] ir_v;
        obs_t        exp;
    } rec_t;

    rec_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   m_tmo  = 1'b0;

    function automatic logic [31:0] sext19(logic [31:0] v);
        logic [31:0] r;
        r = v & 32'h0007FFFF;
        if (r >= 32'h00040000) r = r - 32'h00080000;
        return r;
    endfunction

    function automatic logic [15:0] hot(int n);
        logic [15:0] one;
        one = 16'h0001;
        return one << n;
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.st   = state;
        o.rin  = Rin;
        o.rout = Rout;
        o.fl   = {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, PCout, MDRout,
                  Zlowout, Zhighout, HIout, LOout, Cout, Read, IncPC};
        o.alu  = ALU_Control;
        o.hlt  = halted;
        o.ill  = illegal_op;
        o.tmo  = mem_timeout;
        o.cv   = c_value;
        return o;
    endfunction

    function automatic void push(string tag, int st, logic [15:0] rin, logic [15:0] rout,
                                 logic [16:0] fl, int alu, bit hlt, bit ill,
                                 bit r, bit mr, bit clr, logic [31:0] irv);
        rec_t e;
        e.tag      = tag;
        e.run_v    = r;
        e.mr_v     = mr;
        e.clr_v    = clr;
        e.ir_v     = irv;
        e.exp.st   = 4'(st);
        e.exp.rin  = rin;
        e.exp.rout = rout;
        e.exp.fl   = fl;
        e.exp.alu  = 5'(alu);
        e.exp.hlt  = hlt;
        e.exp.ill  = ill;
        e.exp.tmo  = m_tmo;
        e.exp.cv   = sext19(irv);
        q.push_back(e);
    endfunction

    function automatic bit rb(); return bit'($urandom_range(0, 1)); endfunction

    // Expand one instruction into its expected micro-steps, starting at T0.
    function automatic void add_instr(logic [31:0] irv, int n_wait, string nm);
        int op, ra, rbf, rc, src2, ia;
        op  = int'(irv[31:27]);
        ra  = int'(irv[26:23]);
        rbf = int'(irv[22:19]);
        rc  = int'(irv[18:15]);
        push({nm, ".T0"}, 1, 0, 0, F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 0, 0, 0, rb(), rb(), 0, irv);
        for (int i = 0; i <= n_wait; i++)
            push($sformatf("%s.T1w%0d", nm, i), 2, 0, 0, F_ZLOW | F_PCIN | F_READ | F_MDRIN,
                 0, 0, 0, rb(), (i == n_wait), 0, irv);
        push({nm, ".T2"}, 3, 0, 0, F_MDROUT | F_IRIN, 0, 0, 0, rb(), rb(), 0, irv);
        if ((op >= 3 && op <= 11) || op == 17 || op == 18) begin
            src2 = (op >= 17) ? rbf : rc;
            push({nm, ".T3"}, 4, 0, hot(rbf), F_YIN, 0, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T4"}, 5, 0, hot(src2), F_ZIN, op, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T5"}, 6, hot(ra), 0, F_ZLOW, 0, 0, 0, rb(), rb(), 0, irv);
        end else if (op >= 12 && op <= 14) begin
            ia = (op == 12) ? 3 : (op == 13) ? 5 : 6;
            push({nm, ".T3"}, 4, 0, hot(rbf), F_YIN, 0, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T4"}, 5, 0, 0, F_COUT | F_ZIN, ia, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T5"}, 6, hot(ra), 0, F_ZLOW, 0, 0, 0, rb(), rb(), 0, irv);
        end else if (op == 15 || op == 16) begin
            push({nm, ".T3"}, 4, 0, hot(ra), F_YIN, 0, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T4"}, 5, 0, hot(rbf), F_ZIN, op, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T5"}, 6, 0, 0, F_ZLOW | F_LOIN, 0, 0, 0, rb(), rb(), 0, irv);
            push({nm, ".T6"}, 7, 0, 0, F_ZHIGH | F_HIIN, 0, 0, 0, rb(), rb(), 0, irv);
        end else if (op == 26) begin
            push({nm, ".T3"}, 4, 0, 0, 0, 0, 0, 0, rb(), rb(), 0, irv);
        end else if (op == 27) begin
            push({nm, ".T3"}, 4, 0, 0, 0, 0, 0, 0, rb(), rb(), 0, irv);
            for (int i = 0; i < 3; i++)
                push({nm, ".HALT"}, 8, 0, 0, 0, 0, 1, 0, rb(), rb(), 0, irv);
        end else begin
            push({nm, ".T3"}, 4, 0, 0, 0, 0, 0, 1, rb(), rb(), 0, irv);
        end
    endfunction

    function automatic void do_clear(int prev_st, bit prev_hlt);
        push("clear", prev_st, 0, 0, 0, 0, prev_hlt, 0, rb(), rb(), 1, 32'h0);
        m_tmo = 1'b0;
        push("post_clear", 0, 0, 0, 0, 0, 0, 0, 0, rb(), 0, 32'h0);
    endfunction

    function automatic void start();
        push("start", 0, 0, 0, 0, 0, 0, 0, 1, rb(), 0, 32'h0);
    endfunction

    task automatic play();
        rec_t e;
        obs_t o;
        while (q.size() > 0) begin
            e         = q.pop_front();
            ir        = e.ir_v;
            run       = e.run_v;
            mem_ready = e.mr_v;
            clear     = e.clr_v;
            @(negedge clock);
            o = get_obs();
            n_cmp++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
            @(posedge clock);
            #1;
        end
    endtask

    int          c_ops[17] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 26};
    int          op;
    logic [31:0] rnd;
    rec_t        t4;

    initial begin
        clear = 1'b1;
        @(posedge clock);
        #1;
        push("reset", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0);
        push("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        start();
        play();

        add_instr(32'h1A920000, 0, "add");
        add_instr(32'h618FFFFB, 1, "addi");
        add_instr(32'h7B380000, 0, "mul");
        add_instr(32'h1A920000, 3, "add_wait3");
        add_instr(32'h88900000, 2, "neg");
        add_instr(32'hD0000000, 0, "nop");
        add_instr(32'hF8000000, 0, "illegal");
        add_instr(32'h618FFFFB, 14, "addi_wait14");
        play();

        for (int n = 0; n < 40; n++) begin
            op = c_ops[$urandom_range(0, 16)];
            if ($urandom_range(0, 7) == 0) begin
                op = int'($urandom_range(0, 31));
                if (op == 27) op = 26;
            end
            rnd = $urandom();
            add_instr({5'(op), rnd[26:0]}, int'($urandom_range(0, 6)), $sformatf("rnd%0d", n));
            play();
        end

        // Fetch timeout: 15 T1 cycles with no mem_ready, then HALT with fault
        push("tmo.T0", 1, 0, 0, F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 15; i++)
            push($sformatf("tmo.T1w%0d", i), 2, 0, 0, F_ZLOW | F_PCIN | F_READ | F_MDRIN,
                 0, 0, 0, 0, 0, 0, 32'h0);
        m_tmo = 1'b1;
        push("tmo.HALT", 8, 0, 0, 0, 0, 1, 0, 1, 1, 0, 32'h0);
        push("tmo.HALT", 8, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0);
        do_clear(8, 1);
        start();
        play();

        add_instr(32'hD8000000, 0, "halt");
        do_clear(8, 1);
        start();
        play();

        // clear asserted in T4 of an add
        add_instr(32'h1A920000, 0, "clr_mid");
        void'(q.pop_back());
        t4 = q.pop_back();
        t4.tag      = "clr_mid.T4";
        t4.clr_v    = 1'b1;
        t4.exp.rout = '0;
        t4.exp.fl   = '0;
        t4.exp.alu  = '0;
        q.push_back(t4);
        push("clr_mid.after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1A920000);
        play();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Mini-SRC control unit that sits directly upstream of the datapath and drives all its bus, register and ALU strobes.
- Runs a fetch sequence, then decodes the instruction register into per-step control signals for ALU register, immediate, mul/div, nop and halt instructions.
- Outputs are a Moore decode of the state register plus the IR contents.
- Waits on a memory-ready handshake during instruction fetch.

Parameters:
- AUTO_RUN, 0, if 1 the block leaves IDLE without waiting for run.
- TIMEOUT_CYCLES, 15, maximum cycles T1 may wait for mem_ready before a fault; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- run  in  1  start request, sampled in IDLE.
- mem_ready  in  1  Mdatain valid this cycle.
- ir  in  32  current IR contents (IR register output).
- Rin  out  16  one-hot GPR load enables, bit n = Rn.
- Rout  out  16  one-hot GPR bus drive, bit n = Rn.
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes.
- PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Cout  out  1 each  bus drive selects.
- Read  out  1  MDR takes Mdatain.
- IncPC  out  1  Z takes PC+1.
- ALU_Control  out  5  ALU operation.
- c_value  out  32  ir[18:0] sign-extended to 32 bits; combinational, always valid.
- halted  out  1  high in HALT.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- mem_timeout  out  1  sticky fetch-timeout flag.
- state  out  4  debug encoding of the current state.

Behaviour:
- IR fields:
  - opcode = ir[31:27]
  - Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15]
- Opcodes (binary):
  - add 00011, sub 00100, and 00101, or 00110
  - shr 00111, shra 01000, shl 01001, ror 01010, rol 01011
  - addi 01100, andi 01101, ori 01110
  - mul 01111, div 10000, neg 10001, not 10010
  - nop 11010, halt 11011
- States: IDLE, T0..T6, HALT.
  - Reset state is IDLE.
  - All strobe outputs, halted, illegal_op, mem_timeout and the timeout counter reset to 0.
  - Register-driven outputs (halted, mem_timeout, state) take their reset values on the first clock edge with clear high.
  - While clear is high, every strobe output is forced to 0 combinationally, including mid-instruction.
  - The next state after any edge with clear high is IDLE, overriding every other transition.
- IDLE: all strobes 0. Go to T0 when run=1 or AUTO_RUN=1.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0, holding the same strobes.
  - PC is loaded again each waiting cycle with the same Z value, so the result is unchanged.
  - Go to T2 when mem_ready=1.
  - The wait counter counts cycles spent in T1 and resets on leaving T1.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with mem_ready=0: set mem_timeout and go to HALT.
- T2: MDRout, IRin. Next state T3.
- Register ALU ops (add..rol, neg, not):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], ALU_Control=opcode, Zin. For neg/not, Rout[Rb] replaces Rout[Rc].
  - T5: Zlowout, Rin[Ra]. Then T0.
- addi/andi/ori:
  - T3: Rout[Rb], Yin.
  - T4: Cout, ALU_Control = add/and/or code (00011/00101/00110), Zin.
  - T5: Zlowout, Rin[Ra]. Then T0.
- mul/div:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], ALU_Control=opcode, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin. Then T0.
- nop: T3 asserts nothing. Then T0.
- halt: T3 goes to HALT. HALT asserts halted and no strobes, and is left only by clear.
- Unknown opcode: behaves as nop, and illegal_op pulses high during T3.
- ALU_Control is 00000 in all states not listed above.
- At most one Rin bit and one Rout bit are high in any cycle; R0 is written like any other GPR.
- Exactly one bus-drive select is high in every state except IDLE, nop-T3, HALT, and halt-T3 (which asserts nothing).
- state encoding: IDLE=0, T0..T6=1..7, HALT=8.

Test Plan:
- Reset then run=1 for 1 cycle, mem_ready=1 → T0 asserts PCout/MARin/IncPC/Zin; T1 asserts Read/MDRin/PCin/Zlowout; T2 asserts MDRout/IRin; state sequence 0,1,2,3.
- ir=0x1A920000 (add R5,R2,R4) → T3 Rout=0x0004 with Yin; T4 Rout=0x0010, ALU_Control=00011, Zin; T5 Rin=0x0020 with Zlowout; then T0.
- ir=0x618FFFFB (addi R3,R1,-5) → c_value=0xFFFFFFFB; T4 Cout=1, ALU_Control=00011; T5 Rin=0x0008.
- ir=0x7B380000 (mul R6,R7) → T3 Rout=0x0040; T4 Rout=0x0080, ALU_Control=01111; T5 LOin; T6 HIin with Zhighout; then T0.
- mem_ready held 0 in T1 with TIMEOUT_CYCLES=15 → Read held high for 15 cycles, then mem_timeout=1, halted=1, state=8. With mem_ready=1 on wait cycle 3 → T2 with no fault.
- ir=0xD8000000 (halt) → HALT, halted=1 with no strobes. clear asserted mid-T4 of an add → all strobes 0 in the same cycle, state=0 after the edge. ir opcode 11111 → illegal_op pulses 1 cycle, no Rin write.
